// File: rtl/led_blink_bank.sv
// Bank of NCHAN LED drivers (off / on / blink / burst) sharing one prescaled timebase tick.
// All outputs are registered; channel timing advances only on ticks while en is high.
module led_blink_bank #(
  parameter int unsigned NCHAN    = 8,
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned BURST_N  = 3
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      en,
  input  logic [2*NCHAN-1:0]        mode,
  input  logic [PERIOD_W*NCHAN-1:0] half_period,
  input  logic [NCHAN-1:0]          trig,
  output logic [NCHAN-1:0]          led,
  output logic [NCHAN-1:0]          busy,
  output logic                      tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RW  = $clog2(BURST_N + 1);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("led_blink_bank: CLK_HZ / TICK_HZ must be at least 1");
    end
    if (BURST_N < 1) begin : g_bad_burst
      $error("led_blink_bank: BURST_N must be at least 1");
    end
  endgenerate

  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  // tick is a flop, so gate with the live en to freeze channels in the cycle en drops.
  logic advance;
  assign advance = tick_q & en;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    logic [PERIOD_W-1:0] ph_q, ph_d, hp, ph_step;
    logic [RW-1:0]       rem_q, rem_d;
    logic                led_q, led_d, busy_q, wrap;
    logic [1:0]          prev_q, cur;

    always_comb begin
      cur = mode[2*i +: 2];
      hp  = half_period[PERIOD_W*i +: PERIOD_W];
      if (hp == '0) hp = PERIOD_W'(1);
      wrap    = (ph_q >= hp - 1'b1);
      ph_step = wrap ? '0 : ph_q + 1'b1;

      ph_d  = ph_q;
      rem_d = rem_q;
      led_d = led_q;

      if (cur != prev_q) begin
        ph_d  = '0;
        rem_d = '0;
        led_d = (cur == 2'b01) || (cur == 2'b10);
      end else begin
        unique case (cur)
          2'b00: led_d = 1'b0;
          2'b01: led_d = 1'b1;
          2'b10: begin
            if (advance) begin
              ph_d = ph_step;
              if (wrap) led_d = ~led_q;
            end
          end
          2'b11: begin
            if (trig[i]) begin
              rem_d = RW'(BURST_N);
              led_d = 1'b1;
              ph_d  = '0;
            end else if (advance && (rem_q != '0)) begin
              ph_d = ph_step;
              if (wrap) begin
                led_d = ~led_q;
                // A flash completes on its falling edge.
                if (led_q) rem_d = rem_q - 1'b1;
              end
            end
          end
        endcase
      end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        ph_q   <= '0;
        rem_q  <= '0;
        led_q  <= 1'b0;
        busy_q <= 1'b0;
        prev_q <= 2'b00;
      end else begin
        ph_q   <= ph_d;
        rem_q  <= rem_d;
        led_q  <= led_d;
        busy_q <= (rem_d != '0);
        prev_q <= cur;
      end
    end

    assign led[i]  = led_q;
    assign busy[i] = busy_q;
  end

endmodule
